// File: rtl/interrupt_request_controller.sv
// interrupt_request_controller: latches rising IRQ edges, posts the lowest-index enabled
// request as alert, and masks further requests until the handler retires rti.
module interrupt_request_controller #(
  parameter int NUM_IRQ = 8,
  localparam int CW = $clog2(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               ien_we,
  input  logic [NUM_IRQ-1:0] ien_wdata,
  input  logic               gie_we,
  input  logic               gie_wdata,
  input  logic               interrupt,
  input  logic [31:0]        pci_in,
  input  logic               rti,
  output logic               alert,
  output logic               interrupt_mask,
  output logic [CW-1:0]      cause,
  output logic [NUM_IRQ-1:0] pending,
  output logic [31:0]        epc,
  output logic               spurious_ack
);
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_e;
  state_e             state_q;
  logic [NUM_IRQ-1:0] irq_q, pending_q, pending_d, ien_q, elig, clr;
  logic [CW-1:0]      cause_q, win;
  logic [31:0]        epc_q;
  logic               gie_q, spur_q, take_ack;
  always_comb begin
    elig = pending_q & ien_q;
    win = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) win = elig[i] ? CW'(i) : win;
    take_ack = (state_q == REQ) && interrupt;
    clr = take_ack ? ({{(NUM_IRQ-1){1'b0}}, 1'b1} << cause_q) : '0;
    // a fresh edge on the line being acknowledged survives the clear
    pending_d = (pending_q & ~clr) | (irq & ~irq_q);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      irq_q     <= '0;
      pending_q <= '0;
      ien_q     <= '0;
      gie_q     <= 1'b0;
      cause_q   <= '0;
      epc_q     <= '0;
      spur_q    <= 1'b0;
    end else begin
      irq_q     <= irq;
      pending_q <= pending_d;
      if (ien_we) ien_q <= ien_wdata;
      if (gie_we) gie_q <= gie_wdata;
      if (interrupt && state_q != REQ) spur_q <= 1'b1;
      // once posted, the request is never withdrawn: next-PC logic has committed
      case (state_q)
        IDLE: if (gie_q && |elig) begin
          state_q <= REQ;
          cause_q <= win;
        end
        REQ: if (interrupt) begin
          state_q <= SERVICE;
          epc_q   <= pci_in;
        end
        SERVICE: if (rti) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign alert          = state_q == REQ;
  assign interrupt_mask = state_q == SERVICE;
  assign cause          = cause_q;
  assign pending        = pending_q;
  assign epc            = epc_q;
  assign spurious_ack   = spur_q;
endmodule

// File: tb/tb_interrupt_request_controller.sv
// tb_interrupt_request_controller: directed scenario tasks plus a randomized run
// against a cycle-level behavioural model of the request/service handshake.
module tb_interrupt_request_controller;
  localparam int N = 8;
  logic         clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] irq, ien_wdata, pending;
  logic         ien_we, gie_we, gie_wdata, interrupt, rti;
  logic [31:0]  pci_in, epc;
  logic         alert, interrupt_mask, spurious_ack;
  logic [2:0]   cause;
  int n_cmp = 0, n_err = 0;

  interrupt_request_controller #(.NUM_IRQ(N)) dut (
    .clk(clk), .rst_n(rst_n), .irq(irq), .ien_we(ien_we), .ien_wdata(ien_wdata),
    .gie_we(gie_we), .gie_wdata(gie_wdata), .interrupt(interrupt), .pci_in(pci_in),
    .rti(rti), .alert(alert), .interrupt_mask(interrupt_mask), .cause(cause),
    .pending(pending), .epc(epc), .spurious_ack(spurious_ack)
  );

  always #5 clk = ~clk;

  // behavioural model: a request is either posted, being serviced, or neither
  logic [N-1:0] m_prev, m_pend, m_ien;
  logic         m_gie, m_posted, m_busy, m_spur;
  logic [2:0]   m_cause;
  logic [31:0]  m_epc;

  function automatic logic [2:0] lowest(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return 3'(i);
    return 3'd0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_prev <= '0; m_pend <= '0; m_ien <= '0; m_gie <= 1'b0;
      m_posted <= 1'b0; m_busy <= 1'b0; m_spur <= 1'b0; m_cause <= '0; m_epc <= '0;
    end else begin
      m_pend <= (m_pend & ~((m_posted && interrupt) ? (8'd1 << m_cause) : 8'd0)) | (irq & ~m_prev);
      m_prev <= irq;
      if (ien_we) m_ien <= ien_wdata;
      if (gie_we) m_gie <= gie_wdata;
      if (interrupt && !m_posted) m_spur <= 1'b1;
      if (m_posted) begin
        if (interrupt) begin m_posted <= 1'b0; m_busy <= 1'b1; m_epc <= pci_in; end
      end else if (m_busy) begin
        if (rti) m_busy <= 1'b0;
      end else if (m_gie && (m_pend & m_ien) != 0) begin
        m_posted <= 1'b1;
        m_cause  <= lowest(m_pend & m_ien);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic cfg(input logic [N-1:0] ien, input logic gie);
    ien_we = 1'b1; ien_wdata = ien; gie_we = 1'b1; gie_wdata = gie;
    tick();
    ien_we = 1'b0; gie_we = 1'b0;
  endtask

  task automatic ack(input logic [31:0] pc);
    interrupt = 1'b1; pci_in = pc;
    tick();
    interrupt = 1'b0; pci_in = '0;
  endtask

  task automatic do_rti();
    rti = 1'b1;
    tick();
    rti = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (alert !== 1'b0) begin n_err++; $display("FAIL reset_alert: got %b want 0", alert); end
    n_cmp++; if (interrupt_mask !== 1'b0) begin n_err++; $display("FAIL reset_mask: got %b want 0", interrupt_mask); end
    n_cmp++; if (cause !== 3'd0) begin n_err++; $display("FAIL reset_cause: got %0d want 0", cause); end
    n_cmp++; if (pending !== 8'h00) begin n_err++; $display("FAIL reset_pending: got %h want 00", pending); end
    n_cmp++; if (epc !== 32'h0) begin n_err++; $display("FAIL reset_epc: got %h want 0", epc); end
    n_cmp++; if (spurious_ack !== 1'b0) begin n_err++; $display("FAIL reset_spurious: got %b want 0", spurious_ack); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    cfg(8'h01, 1'b1);
    irq = 8'h01;
    tick();
    n_cmp++; if (pending !== 8'h01) begin n_err++; $display("FAIL single_pending_set: got %h want 01", pending); end
    n_cmp++; if (alert !== 1'b0) begin n_err++; $display("FAIL single_alert_early: got %b want 0", alert); end
    tick();
    n_cmp++; if (alert !== 1'b1) begin n_err++; $display("FAIL single_alert: got %b want 1", alert); end
    n_cmp++; if (cause !== 3'd0) begin n_err++; $display("FAIL single_cause: got %0d want 0", cause); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (alert !== 1'b1) begin n_err++; $display("FAIL single_alert_hold: got %b want 1", alert); end
    end
    ack(32'h0000_0120);
    n_cmp++; if (alert !== 1'b0) begin n_err++; $display("FAIL single_alert_drop: got %b want 0", alert); end
    n_cmp++; if (interrupt_mask !== 1'b1) begin n_err++; $display("FAIL single_mask: got %b want 1", interrupt_mask); end
    n_cmp++; if (epc !== 32'h120) begin n_err++; $display("FAIL single_epc: got %h want 120", epc); end
    n_cmp++; if (pending !== 8'h00) begin n_err++; $display("FAIL single_pending_clr: got %h want 00", pending); end
    repeat (2) tick();
    n_cmp++; if (interrupt_mask !== 1'b1) begin n_err++; $display("FAIL single_mask_hold: got %b want 1", interrupt_mask); end
    do_rti();
    n_cmp++; if (interrupt_mask !== 1'b0) begin n_err++; $display("FAIL single_mask_rti: got %b want 0", interrupt_mask); end
    tick();
    n_cmp++; if (alert !== 1'b0) begin n_err++; $display("FAIL single_level_retrigger: got %b want 0", alert); end
    irq = '0;
    tick();
  endtask

  task automatic test_priority();
    cfg(8'hFF, 1'b1);
    irq = 8'h24;
    repeat (2) tick();
    n_cmp++; if (alert !== 1'b1 || cause !== 3'd2) begin n_err++; $display("FAIL prio_first: got alert=%b cause=%0d want 1/2", alert, cause); end
    ack(32'h200);
    n_cmp++; if (pending !== 8'h20) begin n_err++; $display("FAIL prio_pending: got %h want 20", pending); end
    n_cmp++; if (cause !== 3'd2) begin n_err++; $display("FAIL prio_cause_svc: got %0d want 2", cause); end
    do_rti();
    n_cmp++; if (alert !== 1'b0) begin n_err++; $display("FAIL prio_bubble: got %b want 0", alert); end
    tick();
    n_cmp++; if (alert !== 1'b1 || cause !== 3'd5) begin n_err++; $display("FAIL prio_second: got alert=%b cause=%0d want 1/5", alert, cause); end
    ack(32'h204);
    do_rti();
    irq = '0;
    tick();
  endtask

  task automatic test_masking();
    cfg(8'h00, 1'b1);
    irq = 8'h08;
    tick();
    n_cmp++; if (pending !== 8'h08) begin n_err++; $display("FAIL mask_pending: got %h want 08", pending); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (alert !== 1'b0) begin n_err++; $display("FAIL mask_alert_off: got %b want 0", alert); end
    end
    ien_we = 1'b1; ien_wdata = 8'h08;
    tick();
    ien_we = 1'b0;
    n_cmp++; if (alert !== 1'b0) begin n_err++; $display("FAIL mask_alert_write: got %b want 0", alert); end
    tick();
    n_cmp++; if (alert !== 1'b1 || cause !== 3'd3) begin n_err++; $display("FAIL mask_alert_on: got alert=%b cause=%0d want 1/3", alert, cause); end
    ack(32'h300);
    do_rti();
    irq = '0;
    tick();
  endtask

  task automatic test_gie_during_req();
    cfg(8'h02, 1'b1);
    irq = 8'h02;
    repeat (2) tick();
    n_cmp++; if (alert !== 1'b1 || cause !== 3'd1) begin n_err++; $display("FAIL gie_post: got alert=%b cause=%0d want 1/1", alert, cause); end
    gie_we = 1'b1; gie_wdata = 1'b0;
    tick();
    gie_we = 1'b0;
    repeat (2) tick();
    n_cmp++; if (alert !== 1'b1) begin n_err++; $display("FAIL gie_alert_held: got %b want 1", alert); end
    ack(32'h400);
    n_cmp++; if (alert !== 1'b0 || interrupt_mask !== 1'b1) begin n_err++; $display("FAIL gie_ack: got alert=%b mask=%b want 0/1", alert, interrupt_mask); end
    n_cmp++; if (epc !== 32'h400) begin n_err++; $display("FAIL gie_epc: got %h want 400", epc); end
    do_rti();
    irq = '0;
    tick();
    n_cmp++; if (alert !== 1'b0) begin n_err++; $display("FAIL gie_idle: got %b want 0", alert); end
  endtask

  task automatic test_collision();
    cfg(8'h02, 1'b1);
    irq = 8'h02;
    repeat (2) tick();
    n_cmp++; if (alert !== 1'b1 || cause !== 3'd1) begin n_err++; $display("FAIL coll_post: got alert=%b cause=%0d want 1/1", alert, cause); end
    irq = '0;
    tick();
    irq = 8'h02; interrupt = 1'b1; pci_in = 32'h500;
    tick();
    interrupt = 1'b0; pci_in = '0;
    n_cmp++; if (pending !== 8'h02) begin n_err++; $display("FAIL coll_set_wins: got %h want 02", pending); end
    n_cmp++; if (interrupt_mask !== 1'b1 || epc !== 32'h500) begin n_err++; $display("FAIL coll_ack: got mask=%b epc=%h want 1/500", interrupt_mask, epc); end
    do_rti();
    tick();
    n_cmp++; if (alert !== 1'b1 || cause !== 3'd1) begin n_err++; $display("FAIL coll_reserve: got alert=%b cause=%0d want 1/1", alert, cause); end
    ack(32'h504);
    n_cmp++; if (pending !== 8'h00) begin n_err++; $display("FAIL coll_pending_clr: got %h want 00", pending); end
    do_rti();
    irq = '0;
    tick();
  endtask

  task automatic test_spurious_reset();
    n_cmp++; if (spurious_ack !== 1'b0) begin n_err++; $display("FAIL spur_clean: got %b want 0", spurious_ack); end
    interrupt = 1'b1;
    tick();
    interrupt = 1'b0;
    n_cmp++; if (spurious_ack !== 1'b1) begin n_err++; $display("FAIL spur_set: got %b want 1", spurious_ack); end
    n_cmp++; if (alert !== 1'b0 || interrupt_mask !== 1'b0) begin n_err++; $display("FAIL spur_ignored: got alert=%b mask=%b want 0/0", alert, interrupt_mask); end
    cfg(8'h04, 1'b1);
    irq = 8'h04;
    repeat (2) tick();
    ack(32'h600);
    irq = 8'h14;
    tick();
    n_cmp++; if (interrupt_mask !== 1'b1 || cause !== 3'd2 || pending !== 8'h10) begin
      n_err++; $display("FAIL spur_service: got mask=%b cause=%0d pending=%h want 1/2/10", interrupt_mask, cause, pending);
    end
    rst_n = 1'b0;
    #2;
    n_cmp++; if (interrupt_mask !== 1'b0 || alert !== 1'b0) begin n_err++; $display("FAIL rst_async_fsm: got alert=%b mask=%b want 0/0", alert, interrupt_mask); end
    n_cmp++; if (cause !== 3'd0 || pending !== 8'h00) begin n_err++; $display("FAIL rst_async_regs: got cause=%0d pending=%h want 0/00", cause, pending); end
    n_cmp++; if (epc !== 32'h0 || spurious_ack !== 1'b0) begin n_err++; $display("FAIL rst_async_epc: got epc=%h spur=%b want 0/0", epc, spurious_ack); end
    irq = '0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_random();
    logic [N-1:0] f;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      f = '0;
      for (int j = 0; j < N; j++) if ($urandom_range(5) == 0) f[j] = 1'b1;
      irq = irq ^ f;
      ien_we = ($urandom_range(15) == 0); ien_wdata = N'($urandom);
      gie_we = ($urandom_range(15) == 0); gie_wdata = ($urandom_range(3) != 0);
      interrupt = ($urandom_range(4) == 0); pci_in = $urandom;
      rti = ($urandom_range(5) == 0);
      if (i == 1500) rst_n = 1'b0;
      if (i == 1502) rst_n = 1'b1;
      tick();
      n_cmp++; if (alert !== m_posted) begin n_err++; $display("FAIL rnd_alert @%0d: got %b want %b", i, alert, m_posted); end
      n_cmp++; if (interrupt_mask !== m_busy) begin n_err++; $display("FAIL rnd_mask @%0d: got %b want %b", i, interrupt_mask, m_busy); end
      n_cmp++; if (cause !== m_cause) begin n_err++; $display("FAIL rnd_cause @%0d: got %0d want %0d", i, cause, m_cause); end
      n_cmp++; if (pending !== m_pend) begin n_err++; $display("FAIL rnd_pending @%0d: got %h want %h", i, pending, m_pend); end
      n_cmp++; if (epc !== m_epc) begin n_err++; $display("FAIL rnd_epc @%0d: got %h want %h", i, epc, m_epc); end
      n_cmp++; if (spurious_ack !== m_spur) begin n_err++; $display("FAIL rnd_spurious @%0d: got %b want %b", i, spurious_ack, m_spur); end
    end
    ien_we = 1'b0; gie_we = 1'b0; interrupt = 1'b0; rti = 1'b0; irq = '0;
  endtask

  initial begin
    irq = '0; ien_we = 1'b0; ien_wdata = '0; gie_we = 1'b0; gie_wdata = 1'b0;
    interrupt = 1'b0; pci_in = '0; rti = 1'b0;
    test_reset();
    test_single();
    test_priority();
    test_masking();
    test_gie_during_req();
    test_collision();
    test_spurious_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
